// File: rtl/rf_pkg.sv
// Shared definitions for the register-file BIST: pattern encodings, FSM states
// and the data-pattern generator.
package rf_pkg;

    // Widest register the pattern generator can describe; callers keep the low XLEN bits.
    localparam int PAT_MAX_W = 64;

    localparam logic [1:0] PAT_ADDR  = 2'd0;
    localparam logic [1:0] PAT_NADDR = 2'd1;
    localparam logic [1:0] PAT_CHK   = 2'd2;
    localparam logic [1:0] PAT_WALK  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_e;

    function automatic logic [PAT_MAX_W-1:0] pat(input logic [1:0]  sel,
                                                  input logic [31:0] idx,
                                                  input int unsigned xlen);
        logic [PAT_MAX_W-1:0] v;
        case (sel)
            PAT_ADDR:  v = {32'd0, idx};
            PAT_NADDR: v = ~{32'd0, idx};
            PAT_CHK:   v = idx[0] ? {16{4'h5}} : {16{4'hA}};
            default:   v = 64'd1 << (idx % xlen);
        endcase
        return v;
    endfunction

endpackage

// File: rtl/regfile_bist_if.sv
// Control/status bundle of the register-file BIST engine.
interface regfile_bist_if #(
    parameter int AW = 5
) ();
    logic          start;
    logic [1:0]    pattern_sel;
    logic          inject;
    logic [AW-1:0] inject_addr;
    logic          busy;
    logic          done;
    logic          pass;
    logic          err1;
    logic          err2;
    logic [AW-1:0] fail_addr;
    logic [AW+1:0] err_count;

    modport master (
        output start, pattern_sel, inject, inject_addr,
        input  busy, done, pass, err1, err2, fail_addr, err_count
    );

    modport slave (
        input  start, pattern_sel, inject, inject_addr,
        output busy, done, pass, err1, err2, fail_addr, err_count
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: one synchronous write port, two combinational
// read ports, optional hardwired-zero register 0, no write-to-read bypass.
module regfile_param #(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem [NREGS];

    // NOTE: storage is deliberately left without reset so it maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (we && !(ZERO_REG != 0 && waddr == '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = (ZERO_REG != 0 && raddr1 == '0) ? '0 : mem[raddr1];
    assign rdata2 = (ZERO_REG != 0 && raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/regfile_bist.sv
// BIST engine: fills the register file with a pattern, reads it back through both
// ports (ascending / descending) and reports pass, first failing address and count.
module regfile_bist
    import rf_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           reset,
    regfile_bist_if.slave  bus
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_e          state;
    logic [AW-1:0]   idx;
    logic [1:0]      sel_q;
    logic            inj_q;
    logic [AW-1:0]   inj_addr_q;
    logic            busy_q, done_q, pass_q, err1_q, err2_q;
    logic [AW-1:0]   fail_addr_q;
    logic [AW+1:0]   err_count_q;

    logic [XLEN-1:0] rd1_q, rd2_q, exp1_q, exp2_q;
    logic [AW-1:0]   a1_q, a2_q;
    logic            cmp_valid_q;

    logic [XLEN-1:0] wr_data, rdata1, rdata2, exp1_d, exp2_d;
    logic [PAT_MAX_W-1:0] wr_full, exp1_full, exp2_full;
    logic [AW-1:0]   raddr2;
    logic            mis1, mis2;
    logic [AW+2:0]   cnt_sum;
    logic [AW+1:0]   cnt_next;

    assign raddr2 = LAST - idx;

    // NOTE: every always_comb output gets a value on every path, so no latches appear.
    always_comb begin
        wr_full   = pat(sel_q, 32'(idx), XLEN);
        exp1_full = pat(sel_q, 32'(idx), XLEN);
        exp2_full = pat(sel_q, 32'(raddr2), XLEN);
        wr_data   = wr_full[XLEN-1:0];
        exp1_d    = exp1_full[XLEN-1:0];
        exp2_d    = exp2_full[XLEN-1:0];
        if (inj_q && idx == inj_addr_q) wr_data[0] = ~wr_data[0];
        if (ZERO_REG != 0 && idx == '0)    exp1_d = '0;
        if (ZERO_REG != 0 && raddr2 == '0) exp2_d = '0;
    end

    always_comb begin
        mis1     = cmp_valid_q && (rd1_q != exp1_q);
        mis2     = cmp_valid_q && (rd2_q != exp2_q);
        cnt_sum  = {1'b0, err_count_q} + {{(AW+2){1'b0}}, mis1} + {{(AW+2){1'b0}}, mis2};
        cnt_next = cnt_sum[AW+2] ? '1 : cnt_sum[AW+1:0];
    end

    regfile_param #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_rf (
        .clk    (clk),
        .we     (state == S_WRITE),
        .waddr  (idx),
        .wdata  (wr_data),
        .raddr1 (idx),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    // NOTE: sequential state uses non-blocking assignments only; later writes in the block win.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            sel_q       <= '0;
            inj_q       <= 1'b0;
            inj_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err1_q      <= 1'b0;
            err2_q      <= 1'b0;
            fail_addr_q <= '0;
            err_count_q <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            exp1_q      <= '0;
            exp2_q      <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            cmp_valid_q <= 1'b0;
        end else begin
            busy_q      <= (state != S_IDLE);
            done_q      <= 1'b0;
            cmp_valid_q <= 1'b0;

            // Checker: compares the read data registered in the previous cycle.
            if (mis1 || mis2) begin
                if (!(err1_q || err2_q)) fail_addr_q <= mis1 ? a1_q : a2_q;
                if (mis1) err1_q <= 1'b1;
                if (mis2) err2_q <= 1'b1;
                err_count_q <= cnt_next;
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        sel_q       <= bus.pattern_sel;
                        inj_q       <= bus.inject;
                        inj_addr_q  <= bus.inject_addr;
                        err1_q      <= 1'b0;
                        err2_q      <= 1'b0;
                        fail_addr_q <= '0;
                        err_count_q <= '0;
                        pass_q      <= 1'b0;
                        idx         <= '0;
                        state       <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= S_READ;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_READ: begin
                    rd1_q       <= rdata1;
                    rd2_q       <= rdata2;
                    exp1_q      <= exp1_d;
                    exp2_q      <= exp2_d;
                    a1_q        <= idx;
                    a2_q        <= raddr2;
                    cmp_valid_q <= 1'b1;
                    if (idx == LAST) state <= S_DRAIN;
                    else             idx   <= idx + 1'b1;
                end
                S_DRAIN: state <= S_DONE;
                S_DONE: begin
                    done_q <= 1'b1;
                    pass_q <= (err_count_q == '0);
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err1      = err1_q;
    assign bus.err2      = err2_q;
    assign bus.fail_addr = fail_addr_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: two configurations (32x32 zero-reg, 24x16 plain) checked
// against a behavioural model of write-then-dual-read over the whole register file.
module tb_regfile_bist;

    localparam int AW = 5;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          pass;
        logic          err1;
        logic          err2;
        logic [AW-1:0] fail_addr;
        logic [AW+1:0] err_count;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_bist_if #(.AW(AW)) if_a ();
    regfile_bist_if #(.AW(AW)) if_b ();

    regfile_bist #(.XLEN(32), .NREGS(32), .AW(AW), .ZERO_REG(1)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    regfile_bist #(.XLEN(16), .NREGS(24), .AW(AW), .ZERO_REG(0)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic obs_t get_obs(input int which);
        obs_t o;
        if (which == 0) o = '{if_a.busy, if_a.done, if_a.pass, if_a.err1, if_a.err2, if_a.fail_addr, if_a.err_count};
        else            o = '{if_b.busy, if_b.done, if_b.pass, if_b.err1, if_b.err2, if_b.fail_addr, if_b.err_count};
        return o;
    endfunction

    task automatic set_inputs(input int which, input logic s, input logic [1:0] sel,
                              input logic inj, input logic [AW-1:0] ia);
        if (which == 0) begin
            if_a.start = s; if_a.pattern_sel = sel; if_a.inject = inj; if_a.inject_addr = ia;
        end else begin
            if_b.start = s; if_b.pattern_sel = sel; if_b.inject = inj; if_b.inject_addr = ia;
        end
    endtask

    task automatic set_start(input int which, input logic s);
        if (which == 0) if_a.start = s;
        else            if_b.start = s;
    endtask

    // Value the pattern rules prescribe for register i, in an xlen-bit word.
    function automatic logic [63:0] model_pat(input int sel, input int i, input int xlen);
        logic [63:0] mask;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << xlen) - 64'd1);
        case (sel)
            0:       return 64'(i);
            1:       return mask - 64'(i);
            2:       return ((i % 2 == 0) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555) & mask;
            default: return 64'd1 << (i % xlen);
        endcase
    endfunction

    task automatic model_run(input int nregs, input int xlen, input int zero_reg,
                             input int sel, input int inj, input int iaddr,
                             output int e1, output int e2, output int fail, output int cnt);
        logic [63:0] mem [0:63];
        logic [63:0] d;
        int a [2];
        bit found;
        e1 = 0; e2 = 0; fail = 0; cnt = 0; found = 0;
        for (int k = 0; k < nregs; k++) begin
            d = model_pat(sel, k, xlen);
            if (inj != 0 && k == iaddr) d ^= 64'd1;
            mem[k] = (zero_reg != 0 && k == 0) ? 64'd0 : d;
        end
        for (int i = 0; i < nregs; i++) begin
            bit m [2];
            a[0] = i;
            a[1] = nregs - 1 - i;
            for (int p = 0; p < 2; p++) begin
                d = (zero_reg != 0 && a[p] == 0) ? 64'd0 : model_pat(sel, a[p], xlen);
                m[p] = (mem[a[p]] != d);
            end
            if ((m[0] || m[1]) && !found) begin
                found = 1;
                fail  = m[0] ? a[0] : a[1];
            end
            if (m[0]) e1 = 1;
            if (m[1]) e2 = 1;
            cnt = cnt + int'(m[0]) + int'(m[1]);
            if (cnt > (1 << (AW + 2)) - 1) cnt = (1 << (AW + 2)) - 1;
        end
    endtask

    // One complete run; poke >= 0 raises start for one cycle that many edges into the run.
    task automatic do_run(input int which, input logic [1:0] sel, input logic inj,
                          input logic [AW-1:0] ia, input int poke, input string tag);
        int nregs, xlen, zr, n, e1, e2, fail, cnt;
        obs_t o;
        nregs = (which == 0) ? 32 : 24;
        xlen  = (which == 0) ? 32 : 16;
        zr    = (which == 0) ? 1 : 0;
        model_run(nregs, xlen, zr, int'(sel), int'(inj), int'(ia), e1, e2, fail, cnt);
        @(negedge clk);
        set_inputs(which, 1'b1, sel, inj, ia);
        @(posedge clk);
        n = 0;
        @(negedge clk);
        set_inputs(which, 1'b0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 31));
        while (n < 300) begin
            @(posedge clk);
            n++;
            #1;
            o = get_obs(which);
            set_start(which, (n == poke) ? 1'b1 : 1'b0);
            if (o.done) break;
        end
        check({tag, " latency"}, n, 2 * nregs + 2);
        check({tag, " busy@done"}, o.busy, 1);
        check({tag, " pass"}, o.pass, (cnt == 0) ? 1 : 0);
        check({tag, " err1"}, o.err1, e1);
        check({tag, " err2"}, o.err2, e2);
        check({tag, " fail_addr"}, o.fail_addr, fail);
        check({tag, " err_count"}, o.err_count, cnt);
        @(posedge clk);
        #1;
        o = get_obs(which);
        check({tag, " done pulse"}, o.done, 0);
        check({tag, " busy drop"}, o.busy, 0);
    endtask

    initial begin
        obs_t o;
        int   n, gap, saw_done;

        set_inputs(0, 1'b0, 2'd0, 1'b0, '0);
        set_inputs(1, 1'b0, 2'd0, 1'b0, '0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset values.
        @(posedge clk); #1;
        o = get_obs(0);
        check("rst busy", o.busy, 0);
        check("rst done", o.done, 0);
        check("rst pass", o.pass, 0);
        check("rst err_count", o.err_count, 0);

        // Directed functional cases.
        do_run(0, 2'd0, 1'b0, 5'd0, -1, "A addr");
        do_run(0, 2'd1, 1'b1, 5'd5, -1, "A naddr inj5");
        o = get_obs(0);
        check("A inj5 fail_addr const", o.fail_addr, 5);
        check("A inj5 err_count const", o.err_count, 2);
        check("A inj5 pass const", o.pass, 0);
        do_run(0, 2'd1, 1'b0, 5'd0, -1, "A naddr zero reg");
        check("A zero reg pass const", get_obs(0).pass, 1);
        do_run(0, 2'd1, 1'b1, 5'd0, -1, "A inj on zero reg");
        do_run(1, 2'd3, 1'b0, 5'd0, -1, "B walk");
        check("B walk pass const", get_obs(1).pass, 1);
        do_run(1, 2'd2, 1'b1, 5'd17, -1, "B chk inj17");
        do_run(1, 2'd0, 1'b1, 5'd30, -1, "B inj out of range");
        do_run(0, 2'd2, 1'b0, 5'd0, 20, "A start while busy");

        // Reset in the middle of WRITE aborts the run.
        @(negedge clk); set_inputs(0, 1'b1, 2'd3, 1'b0, '0);
        @(negedge clk); set_start(0, 1'b0);
        repeat (8) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        o = get_obs(0);
        check("midrst busy", o.busy, 0);
        check("midrst err1", o.err1, 0);
        check("midrst fail_addr", o.fail_addr, 0);
        check("midrst state", 32'(u_a.state), 32'(rf_pkg::S_IDLE));
        @(negedge clk); reset = 1'b1;
        saw_done = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (get_obs(0).done) saw_done++;
        end
        check("midrst no done", saw_done, 0);
        check("midrst idx", 32'(u_a.idx), 0);
        do_run(0, 2'd0, 1'b1, 5'd31, -1, "A after reset");

        // start held high: back-to-back runs.
        @(negedge clk); set_inputs(0, 1'b1, 2'd2, 1'b0, '0);
        n = 0;
        while (n < 300) begin
            @(posedge clk); n++; #1;
            if (get_obs(0).done) break;
        end
        for (int r = 0; r < 2; r++) begin
            gap = 0;
            while (gap < 300) begin
                @(posedge clk); gap++; #1;
                if (get_obs(0).done) break;
            end
            check("b2b period", gap, 67);
            check("b2b pass", get_obs(0).pass, 1);
        end
        @(negedge clk); set_start(0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("b2b idle after release", get_obs(0).busy, 0);

        // Randomised runs on both configurations.
        for (int r = 0; r < 6; r++) begin
            do_run(0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), -1, "A rand");
            do_run(1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), -1, "B rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
